// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int N = 3,
    parameter int W = 3
);
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   ack;
    logic           fifo_full;
    logic           fifo_wr;
    logic [W-1:0]   fifo_din;
    logic [N-1:0]   gnt;
    logic           busy;

    modport master (
        input  req, din, fifo_full,
        output ack, fifo_wr, fifo_din, gnt, busy
    );

    modport slave (
        output req, din, fifo_full,
        input  ack, fifo_wr, fifo_din, gnt, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N requesters.
// Define FIFO_WR_ARB_PRIO0_EN to give requester 0 strict priority over the rotation.
module fifo_wr_arbiter #(
    parameter int N     = 3,
    parameter int W     = 3,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          owner_req;
    logic          wr_ok;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [W-1:0]  din_sel;
    logic [W-1:0]  masked [N];

    assign owner_req = bus.req[owner_reg];
    // rst gates the write so nothing is acked in a reset cycle
    assign wr_ok     = rst & (state_reg == ST_BURST) & owner_req & ~bus.fifo_full;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            assign bus.ack[gi] = wr_ok & gnt_reg[gi];
            assign masked[gi]  = gnt_reg[gi] ? bus.din[gi*W +: W] : '0;
        end
    endgenerate

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < N; i++) begin
            din_sel = din_sel | masked[i];
        end
    end

    assign bus.fifo_wr  = wr_ok;
    assign bus.fifo_din = wr_ok ? din_sel : '0;
    assign bus.gnt      = gnt_reg;
    assign bus.busy     = (state_reg == ST_BURST);

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        logic [IW:0] sum;
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (bus.req[sum[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = sum[IW-1:0];
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (bus.req[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_IDLE) begin
            if (pick_valid) begin
                state_next = ST_BURST;
                gnt_next   = N'(1) << pick_idx;
                owner_next = pick_idx;
                cnt_next   = '0;
            end
        end else begin
            if (wr_ok) begin
                cnt_next = cnt_reg + CW'(1);
            end
            if ((wr_ok && cnt_reg == CW'(BURST - 1)) || !owner_req) begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                cnt_next   = '0;
                ptr_next   = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + IW'(1);
`ifdef FIFO_WR_ARB_PRIO0_EN
                // a priority grant to 0 leaves the rotation where it was
                if (owner_reg == '0) begin
                    ptr_next = ptr_reg;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of owner, rotation pointer and words per grant.
module tb_fifo_wr_arbiter;
    localparam int N     = 3;
    localparam int W     = 3;
    localparam int BURST = 4;
    localparam int NW    = 64;
    localparam int BW    = 2 * N + W + 2;
`ifdef FIFO_WR_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_wr_arbiter_if #(.N(N), .W(W)) bus ();

    fifo_wr_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model: owner (-1 = nobody), rotation pointer, words written in current grant
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_wrote = 1'b0;
    int m_wr_idx = 0;

    logic [W-1:0] words [N][NW];
    int pos [N];

    int vectors     = 0;
    int miscompares = 0;

    function automatic bit req_at(int i);
        logic [N-1:0] r;
        r = bus.req >> i;
        return r[0];
    endfunction

    function automatic logic [BW-1:0] model_out();
        logic [N-1:0] a = '0;
        logic [N-1:0] g = '0;
        logic         wr = 1'b0;
        logic [W-1:0] d = '0;
        if (m_owner >= 0) begin
            g = N'(1) << m_owner;
            if (rst && req_at(m_owner) && !bus.fifo_full) begin
                a  = g;
                wr = 1'b1;
                d  = words[m_owner][pos[m_owner]];
            end
        end
        return {a, wr, d, g, (m_owner >= 0)};
    endfunction

    function automatic logic [BW-1:0] observed();
        return {bus.ack, bus.fifo_wr, bus.fifo_din, bus.gnt, bus.busy};
    endfunction

    function automatic int gnt_index();
        for (int i = 0; i < N; i++) begin
            if (bus.gnt == (N'(1) << i)) return i;
        end
        return -1;
    endfunction

    task automatic drive_din();
        for (int i = 0; i < N; i++) begin
            bus.din[i*W +: W] = words[i][pos[i]];
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        m_wrote = 1'b0;
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (bus.req != '0) begin
                int w;
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_at((m_ptr + k) % N)) w = (m_ptr + k) % N;
                end
                if (PRIO && req_at(0)) w = 0;
                m_owner = w;
                m_cnt   = 0;
            end
        end else begin
            int o;
            o = m_owner;
            if (req_at(o) && !bus.fifo_full) begin
                m_wrote  = 1'b1;
                m_wr_idx = o;
                m_cnt++;
                pos[o] = (pos[o] + 1) % NW;
            end
            if (m_cnt == BURST || !req_at(o)) begin
                m_owner = -1;
                m_cnt   = 0;
                if (!(PRIO && o == 0)) m_ptr = (o + 1) % N;
            end
        end
        drive_din();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        bus.req = '0;
        bus.fifo_full = 1'b0;
        drive_din();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < NW; k++) words[i][k] = W'($urandom);
        end
        drive_din();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.req = N'($urandom);
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL reset_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            vectors++;
            if (observed() !== '0) begin
                miscompares++;
                $display("FAIL reset_zero c=%0d got %h exp 0", c, observed());
            end
            tick();
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [W-1:0] exp_d [5] = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        logic [6:0] wr_pat = '0;
        int nd = 0;
        reset_dut();
        for (int k = 0; k < 5; k++) words[1][k] = exp_d[k];
        pos[1] = 0;
        drive_din();
        bus.req = 3'b010;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL single_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (c == 1) begin
                vectors++;
                if (bus.gnt !== 3'b010) begin
                    miscompares++;
                    $display("FAIL single_gnt got %b exp 010", bus.gnt);
                end
            end
            wr_pat[c] = bus.fifo_wr;
            if (bus.fifo_wr && nd < 5) begin
                vectors++;
                if (bus.fifo_din !== exp_d[nd]) begin
                    miscompares++;
                    $display("FAIL single_word%0d got %0d exp %0d", nd, bus.fifo_din, exp_d[nd]);
                end
                nd++;
            end
            tick();
        end
        vectors++;
        if (wr_pat !== 7'b1011110) begin
            miscompares++;
            $display("FAIL single_wr_pattern got %b exp 1011110", wr_pat);
        end
        bus.req = '0;
    endtask

    task automatic test_rotation();
        int order [$];
        int start [$];
        int prev = -1;
        reset_dut();
        randomize_words();
        bus.req = '1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL rotation_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (prev < 0 && gnt_index() >= 0) begin
                order.push_back(gnt_index());
                start.push_back(c);
            end
            prev = gnt_index();
            tick();
        end
        vectors++;
        if (order.size() != 6) begin
            miscompares++;
            $display("FAIL rotation_count got %0d exp 6", order.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (order[k] != (PRIO ? 0 : k % N) || start[k] != 1 + 5 * k) begin
                    miscompares++;
                    $display("FAIL rotation_grant%0d got owner %0d at %0d exp owner %0d at %0d",
                             k, order[k], start[k], PRIO ? 0 : k % N, 1 + 5 * k);
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_full_stall();
        int writes = 0;
        reset_dut();
        randomize_words();
        bus.req = 3'b100;
        for (int c = 0; c < 9; c++) begin
            bus.fifo_full = (c >= 3 && c <= 5);
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL stall_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (c >= 3 && c <= 5) begin
                vectors++;
                if (bus.fifo_wr !== 1'b0 || bus.ack !== '0 || bus.gnt !== 3'b100) begin
                    miscompares++;
                    $display("FAIL stall_hold c=%0d got wr=%b ack=%b gnt=%b exp wr=0 ack=000 gnt=100",
                             c, bus.fifo_wr, bus.ack, bus.gnt);
                end
            end
            if (bus.fifo_wr === 1'b1) writes++;
            if (c == 8) begin
                vectors++;
                if (bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_exit got busy=%b exp 0", bus.busy);
                end
            end
            tick();
        end
        vectors++;
        if (writes != 4) begin
            miscompares++;
            $display("FAIL stall_writes got %0d exp 4", writes);
        end
        bus.fifo_full = 1'b0;
        bus.req = '0;
    endtask

    task automatic test_owner_drop();
        reset_dut();
        randomize_words();
        for (int c = 0; c < 5; c++) begin
            bus.req = (c < 2) ? 3'b111 : 3'b110;
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL drop_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (c == 2) begin
                vectors++;
                if (bus.fifo_wr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drop_nowrite got %b exp 0", bus.fifo_wr);
                end
            end
            if (c == 3 || c == 4) begin
                vectors++;
                if (bus.gnt !== ((c == 3) ? 3'b000 : 3'b010)) begin
                    miscompares++;
                    $display("FAIL drop_gnt c=%0d got %b exp %b", c, bus.gnt,
                             (c == 3) ? 3'b000 : 3'b010);
                end
            end
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        randomize_words();
        bus.req = '1;
        for (int c = 0; c < 5; c++) begin
            rst = (c != 2);
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL rstmid_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (c == 2) begin
                vectors++;
                if (bus.ack !== '0 || bus.fifo_wr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_quiet got ack=%b wr=%b exp ack=000 wr=0", bus.ack, bus.fifo_wr);
                end
            end
            if (c == 3 || c == 4) begin
                vectors++;
                if ({bus.gnt, bus.busy} !== ((c == 3) ? 4'b0000 : 4'b0011)) begin
                    miscompares++;
                    $display("FAIL rstmid_restart c=%0d got gnt=%b busy=%b exp %s", c, bus.gnt, bus.busy,
                             (c == 3) ? "gnt=000 busy=0" : "gnt=001 busy=1");
                end
            end
            tick();
        end
        rst = 1'b1;
        bus.req = '0;
    endtask

`ifdef FIFO_WR_ARB_PRIO0_EN
    task automatic test_prio0();
        int order [$];
        int prev = -1;
        reset_dut();
        randomize_words();
        for (int c = 0; c < 16; c++) begin
            bus.req = (c < 2) ? 3'b010 : (c == 2) ? 3'b000 : (c < 13) ? 3'b111 : 3'b110;
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL prio_bundle c=%0d got %h exp %h", c, observed(), model_out());
            end
            if (prev < 0 && gnt_index() >= 0) order.push_back(gnt_index());
            prev = gnt_index();
            tick();
        end
        vectors++;
        if (order.size() != 4 || order[0] != 1 || order[1] != 0 || order[2] != 0 || order[3] != 2) begin
            miscompares++;
            $display("FAIL prio_order got %p exp '{1, 0, 0, 2}", order);
        end
        bus.req = '0;
    endtask
`endif

    task automatic test_random();
        reset_dut();
        randomize_words();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_at(i)) begin
                    if (m_wrote && m_wr_idx == i) bus.req[i] = ($urandom_range(0, 3) != 0);
                    else if ($urandom_range(0, 19) == 0) bus.req[i] = 1'b0;
                end else begin
                    bus.req[i] = ($urandom_range(0, 2) == 0);
                end
            end
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 49) != 0);
            @(negedge clk);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL random_bundle c=%0d req=%b full=%b rst=%b got %h exp %h",
                         c, bus.req, bus.fifo_full, rst, observed(), model_out());
            end
            tick();
        end
        rst = 1'b1;
        bus.req = '0;
        bus.fifo_full = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) pos[i] = 0;
        bus.req = '0;
        bus.din = '0;
        bus.fifo_full = 1'b0;
        randomize_words();
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_owner_drop();
        test_reset_mid_burst();
`ifdef FIFO_WR_ARB_PRIO0_EN
        test_prio0();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
